instr_mem_writer: RTL and testbench

Streaming RV32I instruction encoder and writer. Accepts decoded instruction fields through a valid/ready handshake, packs them into the 32-bit R/I/S/B/U/J word the core's instruction decoder expects, and writes the words to consecutive instruction-memory addresses. It sits between the program loader/test harness and the instruction memory write port, and it is the producing end of the word layout the decoder consumes.

---
 rtl/rv32i_pkg.sv | 54 +++++
 rtl/instr_format_encoder.sv | 57 +++++
 rtl/instr_mem_writer.sv | 179 +++++++++++++++++
 tb/tb_instr_mem_writer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I definitions used by the instruction-memory writer and by the
// decoder side: base opcodes, the instruction format enum, the writer FSM state
// enum, and an opcode-to-format lookup.
// -----------------------------------------------------------------------------
package rv32i_pkg;

    // Base opcodes (bits [6:0] of every 32-bit instruction word).
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_ILLEGAL
    } fmt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FULL,
        ST_DONE,
        ST_ERROR
    } wr_state_t;

    // Map an opcode to its encoding format; anything unsupported is ILLEGAL.
    function automatic fmt_t opcode_fmt(input logic [6:0] op);
        fmt_t f;
        case (op)
            OP_OP:                                   f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:     f = FMT_I;
            OP_STORE:                                f = FMT_S;
            OP_BRANCH:                               f = FMT_B;
            OP_LUI, OP_AUIPC:                        f = FMT_U;
            OP_JAL:                                  f = FMT_J;
            default:                                 f = FMT_ILLEGAL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_format_encoder.sv
// -----------------------------------------------------------------------------
// instr_format_encoder
// Purely combinational RV32I packer: places the decoded fields and the
// architectural immediate into the 32-bit R/I/S/B/U/J word layout.
//
// Ports
//   opcode  in  7   : word bits [6:0], also selects the format
//   rd      in  5   : destination register
//   rs1     in  5   : source register 1
//   rs2     in  5   : source register 2
//   funct3  in  3   : function field
//   funct7  in  7   : function field (R-type only)
//   imm     in  32  : signed immediate, unscrambled
//   word    out 32  : encoded instruction (0 when illegal)
//   legal   out 1   : opcode is supported
// -----------------------------------------------------------------------------
module instr_format_encoder
    import rv32i_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    fmt_t fmt;

    assign fmt = opcode_fmt(opcode);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        word  = 32'h0;
        legal = 1'b1;
        unique case (fmt)
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            // Shift-immediate funct7 bits already live in imm[11:5].
            FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            // B and J drop imm[0]: targets are always halfword aligned.
            FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3,
                           imm[4:1], imm[11], opcode};
            FMT_U: word = {imm[31:12], rd, opcode};
            FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: begin
                word  = 32'h0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_mem_writer.sv
// -----------------------------------------------------------------------------
// instr_mem_writer
// Streaming RV32I encoder/writer. Accepts field bundles over valid/ready,
// encodes them, and writes the words to consecutive instruction-memory word
// addresses starting at 0 for each load session.
//
// Ports
//   clk          in  1            : rising-edge clock
//   reset        in  1            : synchronous, active-high reset
//   start        in  1            : open a session at address 0
//   finish       in  1            : close the current session
//   in_valid     in  1            : field bundle valid
//   in_ready     out 1            : bundle can be accepted (state LOAD)
//   opcode..imm  in               : decoded instruction fields
//   mem_wen      out 1            : one-cycle write strobe
//   mem_addr     out ADDR_WIDTH   : word address
//   mem_wdata    out 32           : encoded instruction
//   count        out ADDR_WIDTH+1 : words accepted this session
//   full         out 1            : count == DEPTH
//   done         out 1            : session closed by finish
//   err_illegal  out 1            : sticky unsupported-opcode flag
// -----------------------------------------------------------------------------
module instr_mem_writer
    import rv32i_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  finish,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [31:0]           imm,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  done,
    output logic                  err_illegal
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);

    wr_state_t state_q, state_d;

    logic                  mem_wen_q, mem_wen_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [31:0]           enc_word;
    logic                  enc_legal;
    logic                  accept;
    logic                  legal_acc;
    logic                  illegal_acc;
    logic                  session_open;
    logic [ADDR_WIDTH:0]   count_inc;

    instr_format_encoder u_encoder (
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7),
        .imm    (imm),
        .word   (enc_word),
        .legal  (enc_legal)
    );

    assign accept       = in_valid & in_ready;
    assign legal_acc    = accept & enc_legal;
    assign illegal_acc  = accept & ~enc_legal;
    // start while already loading is ignored, so it only opens a session
    // from the other states.
    assign session_open = start & (state_q != ST_LOAD);
    assign count_inc    = count_q + ONE_C;

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: begin
                // An illegal opcode outranks finish; finish outranks filling,
                // while full still reports the fill through count.
                if (illegal_acc)
                    state_d = ST_ERROR;
                else if (finish)
                    state_d = ST_DONE;
                else if (legal_acc && (count_inc == DEPTH_C))
                    state_d = ST_FULL;
            end
            default: begin
                if (start) state_d = ST_LOAD;
            end
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_LOAD);
    end

    // ---------------------------------------------------------- datapath
    always_comb begin
        mem_wen_d   = legal_acc;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        count_d     = count_q;
        done_d      = done_q;
        err_d       = err_q;

        if (legal_acc) begin
            mem_addr_d  = count_q[ADDR_WIDTH-1:0];
            mem_wdata_d = enc_word;
            count_d     = count_inc;
        end

        if (illegal_acc) begin
            err_d = 1'b1;
        end

        if ((state_q == ST_LOAD) && finish && !illegal_acc) begin
            done_d = 1'b1;
        end

        if (session_open) begin
            count_d = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    // Reset also drops any write registered by the previous accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            count_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_wen     = mem_wen_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign count       = count_q;
    assign full        = (count_q == DEPTH_C);
    assign done        = done_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_mem_writer.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_writer
// Directed bench for instr_mem_writer: a default-size instance for encoding,
// sessions, errors and reset, and a DEPTH=4 instance for the fill boundary.
// -----------------------------------------------------------------------------
module tb_instr_mem_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, finish, in_valid;
    logic        start4, finish4, in_valid4;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;

    logic        in_ready, mem_wen, full, done, err_illegal;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [10:0] count;

    logic        in_ready4, mem_wen4, full4, done4, err_illegal4;
    logic [1:0]  mem_addr4;
    logic [31:0] mem_wdata4;
    logic [2:0]  count4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    instr_mem_writer #(.ADDR_WIDTH(10), .DEPTH(1024)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .done(done), .err_illegal(err_illegal)
    );

    instr_mem_writer #(.ADDR_WIDTH(2), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .finish(finish4),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .mem_wen(mem_wen4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .count(count4), .full(full4), .done(done4), .err_illegal(err_illegal4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] im);
        opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    localparam logic [31:0] ADD_WORD = 32'h002081B3;

    // Back-to-back vectors; fields a format does not define are deliberately non-zero.
    logic [6:0]  t_op  [4] = '{7'b0010011, 7'b0100011, 7'b1100011, 7'b1101111};
    logic [4:0]  t_rd  [4] = '{5'd1, 5'd5, 5'd9, 5'd1};
    logic [4:0]  t_rs1 [4] = '{5'd0, 5'd1, 5'd0, 5'd7};
    logic [4:0]  t_rs2 [4] = '{5'd31, 5'd2, 5'd0, 5'd3};
    logic [2:0]  t_f3  [4] = '{3'd0, 3'd2, 3'd0, 3'd5};
    logic [6:0]  t_f7  [4] = '{7'h7F, 7'h55, 7'h2A, 7'h11};
    logic [31:0] t_imm [4] = '{32'hFFFF_FFFF, 32'h0000_0008, 32'hFFFF_FFFC, 32'h0000_0800};
    logic [31:0] t_exp [4] = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h001000EF};

    initial begin
        reset = 1'b1;
        start = 0; finish = 0; in_valid = 0;
        start4 = 0; finish4 = 0; in_valid4 = 0;
        set_fields(7'b0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        tick(); tick();

        // Reset state
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_done", done, 0);
        check("rst_err", err_illegal, 0);
        reset = 1'b0;
        tick();
        check("idle_in_ready", in_ready, 0);

        // Open session, single add
        start = 1; tick(); start = 0;
        check("load_in_ready", in_ready, 1);
        set_fields(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF);
        in_valid = 1; tick(); in_valid = 0;
        check("add_wen", mem_wen, 1);
        check("add_addr", mem_addr, 0);
        check("add_wdata", mem_wdata, ADD_WORD);
        check("add_count", count, 1);
        tick();
        check("add_wen_pulse", mem_wen, 0);

        // start in LOAD is ignored
        start = 1; tick(); start = 0;
        check("start_in_load_count", count, 1);

        finish = 1; tick(); finish = 0;
        check("finish_done", done, 1);
        check("finish_in_ready", in_ready, 0);
        start = 1; tick(); start = 0;
        check("restart_done", done, 0);
        check("restart_count", count, 0);
        check("restart_in_ready", in_ready, 1);

        // Back-to-back accepts
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            set_fields(t_op[i], t_rd[i], t_rs1[i], t_rs2[i], t_f3[i], t_f7[i], t_imm[i]);
            tick();
            check($sformatf("b2b%0d_wen", i), mem_wen, 1);
            check($sformatf("b2b%0d_addr", i), mem_addr, 64'(i));
            check($sformatf("b2b%0d_wdata", i), mem_wdata, t_exp[i]);
        end
        in_valid = 0;
        tick();
        check("b2b_wen_end", mem_wen, 0);
        check("b2b_count", count, 4);

        // Illegal opcode
        set_fields(7'b0000000, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        in_valid = 1; tick(); in_valid = 0;
        check("ill_err", err_illegal, 1);
        check("ill_wen", mem_wen, 0);
        check("ill_count", count, 4);
        check("ill_in_ready", in_ready, 0);
        tick();
        check("ill_in_ready_hold", in_ready, 0);
        check("ill_err_sticky", err_illegal, 1);
        finish = 1; tick(); finish = 0;
        check("finish_in_error_done", done, 0);
        start = 1; tick(); start = 0;
        check("ill_clear_err", err_illegal, 0);
        check("ill_clear_count", count, 0);
        check("ill_clear_in_ready", in_ready, 1);

        // finish together with a legal accept
        set_fields(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        in_valid = 1; finish = 1; tick(); in_valid = 0; finish = 0;
        check("fin_acc_wen", mem_wen, 1);
        check("fin_acc_addr", mem_addr, 0);
        check("fin_acc_wdata", mem_wdata, ADD_WORD);
        check("fin_acc_done", done, 1);
        check("fin_acc_in_ready", in_ready, 0);
        check("fin_acc_count", count, 1);

        // reset in the cycle after an accept drops the next write
        start = 1; tick(); start = 0;
        in_valid = 1; tick();
        check("pre_rst_wen", mem_wen, 1);
        reset = 1; tick();
        check("mid_rst_wen", mem_wen, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_done", done, 0);
        reset = 0; in_valid = 0; tick();
        check("post_rst_idle", in_ready, 0);

        // DEPTH=4 fill boundary
        start4 = 1; tick(); start4 = 0;
        in_valid4 = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("d4_%0d_wen", i), mem_wen4, 1);
            check($sformatf("d4_%0d_addr", i), mem_addr4, 64'(i));
        end
        check("d4_full", full4, 1);
        check("d4_count", count4, 4);
        check("d4_in_ready", in_ready4, 0);
        tick();
        check("d4_fifth_held", mem_wen4, 0);
        check("d4_count_hold", count4, 4);
        in_valid4 = 0;

        // DEPTH=4: finish on the filling accept
        start4 = 1; tick(); start4 = 0;
        check("d4b_full_clear", full4, 0);
        check("d4b_count_clear", count4, 0);
        in_valid4 = 1;
        for (int i = 0; i < 3; i++) tick();
        finish4 = 1; tick(); finish4 = 0; in_valid4 = 0;
        check("d4b_wen", mem_wen4, 1);
        check("d4b_addr", mem_addr4, 3);
        check("d4b_done", done4, 1);
        check("d4b_full", full4, 1);
        check("d4b_in_ready", in_ready4, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
